// File: rtl/fp_adder_issue_arbiter.sv
// ---------------------------------------------------------------------------
// fp_adder_issue_arbiter
//   Shares one fixed-latency FP adder pipeline among NUM_REQ requesters.
//   A round-robin arbiter issues at most one add per cycle. A {valid,id}
//   tag shift register follows each op down the adder so its result can be
//   routed back to the requester that issued it.
//
// Parameters
//   NUM_REQ     number of requesters (2..8)
//   LATENCY     adder depth, fpa_valid -> matching fpa_result (>=1)
//   DATA_WIDTH  operand/result width
//   ID_WIDTH    requester index width
//
// Ports
//   clk, reset            clock; asynchronous active-high reset
//   req_valid             per-requester add pending
//   req_operand1/2        packed operands, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//   req_grant             one-hot combinational grant (operands taken this cycle)
//   flush                 kill all in-flight ops, block grants this cycle
//   fpa_valid             registered issue strobe to adder stage 1
//   fpa_operand1/2        registered operands to adder
//   fpa_result            adder output, LATENCY cycles after fpa_valid
//   resp_valid/resp_id    result ownership for the current fpa_result
//   resp_result           pass-through of fpa_result
//
// Build option
//   FP_ARB_PERF_EN  adds perf_issue_count (32 bits per requester) and
//                   perf_conflict_count (cycles with >=2 requests, no flush).
// ---------------------------------------------------------------------------
module fp_adder_issue_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int LATENCY    = 4,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_operand1,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_operand2,
  output logic [NUM_REQ-1:0]            req_grant,
  input  logic                          flush,
  output logic                          fpa_valid,
  output logic [DATA_WIDTH-1:0]         fpa_operand1,
  output logic [DATA_WIDTH-1:0]         fpa_operand2,
  input  logic [DATA_WIDTH-1:0]         fpa_result,
  output logic                          resp_valid,
  output logic [ID_WIDTH-1:0]           resp_id,
  output logic [DATA_WIDTH-1:0]         resp_result
`ifdef FP_ARB_PERF_EN
  ,
  output logic [NUM_REQ*32-1:0]         perf_issue_count,
  output logic [31:0]                   perf_conflict_count
`endif
);

  // -------------------------------------------------------------------------
  // Round-robin arbitration
  // -------------------------------------------------------------------------
  logic [ID_WIDTH-1:0] rr_ptr_q, rr_ptr_d;
  logic [ID_WIDTH-1:0] win_id;
  logic                win_found;
  logic                grant_any;

  // Scan from rr_ptr upward with wrap; first pending requester wins.
  always_comb begin
    int idx;
    idx       = 0;
    win_found = 1'b0;
    win_id    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(rr_ptr_q) + k) % NUM_REQ;
      if (!win_found && req_valid[idx]) begin
        win_found = 1'b1;
        win_id    = ID_WIDTH'(idx);
      end
    end
  end

  assign grant_any = win_found & ~flush;

  always_comb begin
    req_grant = '0;
    if (grant_any) req_grant[win_id] = 1'b1;
  end

  // Pointer moves just past the winner so a continuously requesting
  // agent is reached within NUM_REQ grants.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (grant_any) rr_ptr_d = ID_WIDTH'((int'(win_id) + 1) % NUM_REQ);
  end

  // -------------------------------------------------------------------------
  // Issue register
  // -------------------------------------------------------------------------
  logic                  fpa_valid_q, fpa_valid_d;
  logic [DATA_WIDTH-1:0] fpa_op1_q, fpa_op1_d;
  logic [DATA_WIDTH-1:0] fpa_op2_q, fpa_op2_d;
  logic [ID_WIDTH-1:0]   issue_id_q, issue_id_d;

  // Operands hold when nothing issues; only the strobe drops.
  always_comb begin
    fpa_valid_d = grant_any;
    fpa_op1_d   = fpa_op1_q;
    fpa_op2_d   = fpa_op2_q;
    issue_id_d  = issue_id_q;
    if (grant_any) begin
      fpa_op1_d  = req_operand1[win_id*DATA_WIDTH +: DATA_WIDTH];
      fpa_op2_d  = req_operand2[win_id*DATA_WIDTH +: DATA_WIDTH];
      issue_id_d = win_id;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr_q    <= '0;
      fpa_valid_q <= 1'b0;
      fpa_op1_q   <= '0;
      fpa_op2_q   <= '0;
      issue_id_q  <= '0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      fpa_valid_q <= fpa_valid_d;
      fpa_op1_q   <= fpa_op1_d;
      fpa_op2_q   <= fpa_op2_d;
      issue_id_q  <= issue_id_d;
    end
  end

  assign fpa_valid    = fpa_valid_q;
  assign fpa_operand1 = fpa_op1_q;
  assign fpa_operand2 = fpa_op2_q;

  // -------------------------------------------------------------------------
  // Tag pipe: entry k holds the op that entered the adder k+1 cycles ago,
  // so the last entry lines up with fpa_result. No stall, shifts every cycle.
  // -------------------------------------------------------------------------
  logic [LATENCY-1:0]               tag_vld_q;
  logic [LATENCY-1:0][ID_WIDTH-1:0] tag_id_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tag_vld_q <= '0;
      tag_id_q  <= '0;
    end else begin
      // The op sitting in the issue register during a flush is killed too.
      tag_vld_q[0] <= fpa_valid_q & ~flush;
      tag_id_q[0]  <= issue_id_q;
      for (int k = 1; k < LATENCY; k++) begin
        tag_vld_q[k] <= tag_vld_q[k-1] & ~flush;
        tag_id_q[k]  <= tag_id_q[k-1];
      end
    end
  end

  // A result emerging in the flush cycle itself belongs to an op issued
  // before the flush, so it is suppressed as well.
  assign resp_valid  = tag_vld_q[LATENCY-1] & ~flush;
  assign resp_id     = tag_id_q[LATENCY-1];
  assign resp_result = fpa_result;

`ifdef FP_ARB_PERF_EN
  // -------------------------------------------------------------------------
  // Performance counters (wrap modulo 2^32)
  // -------------------------------------------------------------------------
  logic [NUM_REQ-1:0][31:0] perf_issue_q;
  logic [31:0]              perf_conflict_q;
  logic                     conflict;

  always_comb begin
    int cnt;
    cnt = 0;
    for (int i = 0; i < NUM_REQ; i++) cnt = cnt + int'(req_valid[i]);
    conflict = (cnt >= 2) && !flush;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_issue_q    <= '0;
      perf_conflict_q <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++)
        if (req_grant[i]) perf_issue_q[i] <= perf_issue_q[i] + 32'd1;
      if (conflict) perf_conflict_q <= perf_conflict_q + 32'd1;
    end
  end

  assign perf_issue_count    = perf_issue_q;
  assign perf_conflict_count = perf_conflict_q;
`endif

endmodule
